// File: rtl/tile_map_addresser_if.sv
// Scan-position, map-write and tile-result signals between the tile addresser and its neighbours.
interface tile_map_addresser_if;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] scrollX;
    logic        levelLoad;
    logic        wrReq;
    logic [4:0]  wrCol;
    logic [3:0]  wrRow;
    logic [1:0]  wrType;
    logic        wrAck;
    logic        busy;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [1:0]  Tile_type;
    logic        insideMap;

    modport master (
        output startOfFrame, pixelX, pixelY, scrollX, levelLoad,
        output wrReq, wrCol, wrRow, wrType,
        input  wrAck, busy, offsetX, offsetY, Tile_type, insideMap
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, scrollX, levelLoad,
        input  wrReq, wrCol, wrRow, wrType,
        output wrAck, busy, offsetX, offsetY, Tile_type, insideMap
    );
endinterface

// File: rtl/tile_map_addresser.sv
// Scroll-wrapped scan position -> tile offsets/type from an internal map; 2-cycle read latency, writes held until wrAck.
// Map writes wait while a level load runs; TILE_MAP_GRID_DEBUG_EN forces floor type on tile borders.
module tile_map_addresser #(
    parameter int TILE_X_BITS = 6,
    parameter int TILE_Y_BITS = 5,
    parameter int MAP_COLS    = 20,
    parameter int MAP_ROWS    = 15,
    parameter int SCREEN_W    = 640
) (
    input logic                 clk,
    input logic                 reset,
    tile_map_addresser_if.slave bus
);
    localparam int MAP_SIZE = MAP_COLS * MAP_ROWS;
    localparam int IDX_W    = $clog2(MAP_SIZE);
    localparam int COL_W    = $clog2(MAP_COLS);
    localparam int ROW_W    = $clog2(MAP_ROWS);
    localparam int WORLD_W  = MAP_COLS << TILE_X_BITS;
    localparam int MAP_H    = MAP_ROWS << TILE_Y_BITS;

    typedef enum logic {LOAD, IDLE} state_t;

    state_t           state;
    logic [IDX_W-1:0] load_idx;
    logic [COL_W-1:0] load_col;
    logic [ROW_W-1:0] load_row;
    logic [1:0]       load_dat;

    logic [1:0]       map_mem [MAP_SIZE];
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [1:0]       mem_wdat;

    logic             wr_accept;
    logic             wr_in_range;
    logic [10:0]      wr_addr_full;

    logic [10:0]      scroll_lat;
    logic [11:0]      sum_x;
    logic [11:0]      world_x;
    logic             vld_n;
    logic [10:0]      rd_addr_full;

    logic                   s1_vld;
    logic [IDX_W-1:0]       s1_addr;
    logic [TILE_X_BITS-1:0] s1_offx;
    logic [TILE_Y_BITS-1:0] s1_offy;
    logic [1:0]             tile_n;

    // Default level: floor along the bottom row, a gift every fourth column just above it.
    always_comb begin
        load_dat = 2'b00;
        if (load_row == ROW_W'(MAP_ROWS - 1)) begin
            load_dat = 2'b01;
        end else if (load_row == ROW_W'(MAP_ROWS - 2) && load_col[1:0] == 2'd2) begin
            load_dat = 2'b10;
        end
    end

    // A held request is only re-accepted once the previous ack has dropped.
    always_comb begin
        wr_accept    = (state == IDLE) && bus.wrReq && !bus.wrAck && !bus.levelLoad;
        wr_in_range  = (bus.wrCol < 5'(MAP_COLS)) && (bus.wrRow < 4'(MAP_ROWS));
        wr_addr_full = 11'(bus.wrRow) * 11'(MAP_COLS) + 11'(bus.wrCol);
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = load_idx;
        mem_wdat  = load_dat;
        if (state == LOAD) begin
            mem_we = 1'b1;
        end else if (wr_accept && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = IDX_W'(wr_addr_full);
            mem_wdat  = bus.wrType;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            map_mem[mem_waddr] <= mem_wdat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            load_idx  <= '0;
            load_col  <= '0;
            load_row  <= '0;
            bus.busy  <= 1'b1;
            bus.wrAck <= 1'b0;
        end else begin
            bus.wrAck <= wr_accept;
            case (state)
                LOAD: begin
                    if (load_idx == IDX_W'(MAP_SIZE - 1)) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        load_idx <= load_idx + 1'b1;
                        if (load_col == COL_W'(MAP_COLS - 1)) begin
                            load_col <= '0;
                            load_row <= load_row + 1'b1;
                        end else begin
                            load_col <= load_col + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (bus.levelLoad) begin
                        state    <= LOAD;
                        bus.busy <= 1'b1;
                        load_idx <= '0;
                        load_col <= '0;
                        load_row <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_lat <= '0;
        end else if (bus.startOfFrame) begin
            scroll_lat <= (bus.scrollX < 11'(WORLD_W)) ? bus.scrollX : '0;
        end
    end

    // One subtraction suffices for every on-screen column; off-screen results are discarded via vld.
    always_comb begin
        sum_x        = {1'b0, bus.pixelX} + {1'b0, scroll_lat};
        world_x      = (sum_x >= 12'(WORLD_W)) ? sum_x - 12'(WORLD_W) : sum_x;
        vld_n        = (bus.pixelX < 11'(SCREEN_W)) && (bus.pixelY < 11'(MAP_H));
        rd_addr_full = 11'(bus.pixelY[10:TILE_Y_BITS]) * 11'(MAP_COLS)
                     + 11'(world_x[11:TILE_X_BITS]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            s1_offx <= '0;
            s1_offy <= '0;
        end else begin
            s1_vld  <= vld_n;
            s1_addr <= vld_n ? IDX_W'(rd_addr_full) : '0;
            s1_offx <= world_x[TILE_X_BITS-1:0];
            s1_offy <= bus.pixelY[TILE_Y_BITS-1:0];
        end
    end

    always_comb begin
        tile_n = (s1_vld && !bus.busy) ? map_mem[s1_addr] : 2'b00;
`ifdef TILE_MAP_GRID_DEBUG_EN
        if (s1_vld && (s1_offx == '0 || s1_offy == '0)) begin
            tile_n = 2'b01;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.Tile_type <= 2'b00;
            bus.offsetX   <= '0;
            bus.offsetY   <= '0;
            bus.insideMap <= 1'b0;
        end else begin
            bus.Tile_type <= tile_n;
            bus.offsetX   <= 11'(s1_offx);
            bus.offsetY   <= 11'(s1_offy);
            bus.insideMap <= s1_vld;
        end
    end
endmodule

// File: tb/tb_tile_map_addresser.sv
// Directed and randomized checks of tile_map_addresser against an arithmetic map/scroll model.
module tb_tile_map_addresser;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    logic [1:0] ref_map [15][20];
    int         scroll_ref = 0;

    always #5 clk = ~clk;

    tile_map_addresser_if dut_if ();

    tile_map_addresser dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic ref_load();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++)
                ref_map[r][c] = (r == 14) ? 2'b01 : ((r == 13 && c % 4 == 2) ? 2'b10 : 2'b00);
    endtask

    // Counts busy cycles from the current point; also clears a one-shot levelLoad.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            dut_if.levelLoad = 1'b0;
            if (!dut_if.busy) break;
            n++;
        end
    endtask

    task automatic probe(input int px, input int py, input string tag);
        int wx;
        int ex_tile;
        bit v;
        dut_if.pixelX = 11'(px);
        dut_if.pixelY = 11'(py);
        @(negedge clk);
        @(negedge clk);
        v  = (px < 640) && (py < 480);
        wx = (px + scroll_ref) % 1280;
        ex_tile = 0;
        if (v) ex_tile = ref_map[py / 32][wx / 64];
`ifdef TILE_MAP_GRID_DEBUG_EN
        if (v && (wx % 64 == 0 || py % 32 == 0)) ex_tile = 1;
`endif
        check({tag, ".offX"}, 32'(dut_if.offsetX), 32'(wx % 64));
        check({tag, ".offY"}, 32'(dut_if.offsetY), 32'(py % 32));
        check({tag, ".tile"}, 32'(dut_if.Tile_type), 32'(ex_tile));
        check({tag, ".inside"}, 32'(dut_if.insideMap), 32'(v));
    endtask

    task automatic set_scroll(input int s);
        dut_if.startOfFrame = 1'b1;
        dut_if.scrollX      = 11'(s);
        @(negedge clk);
        dut_if.startOfFrame = 1'b0;
        scroll_ref = (s < 1280) ? s : 0;
    endtask

    task automatic do_write(input int c, input int r, input int t, input string tag);
        int k;
        k = 0;
        dut_if.wrReq  = 1'b1;
        dut_if.wrCol  = 5'(c);
        dut_if.wrRow  = 4'(r);
        dut_if.wrType = 2'(t);
        do begin
            @(negedge clk);
            k++;
        end while (!dut_if.wrAck && k < 20);
        dut_if.wrReq = 1'b0;
        check({tag, ".ack_lat"}, 32'(k), 32'd1);
        @(negedge clk);
        check({tag, ".ack_pulse"}, 32'(dut_if.wrAck), 32'd0);
        if (c < 20 && r < 15) ref_map[r][c] = 2'(t);
    endtask

    initial begin
        int n;
        int k;
        int ack_early;
        int tile_bad;
        logic [3:0] pat;

        dut_if.startOfFrame = 1'b0;
        dut_if.pixelX       = '0;
        dut_if.pixelY       = '0;
        dut_if.scrollX      = '0;
        dut_if.levelLoad    = 1'b0;
        dut_if.wrReq        = 1'b0;
        dut_if.wrCol        = '0;
        dut_if.wrRow        = '0;
        dut_if.wrType       = '0;
        ref_load();

        repeat (3) @(negedge clk);
        check("rst.tile", 32'(dut_if.Tile_type), 32'd0);
        check("rst.offX", 32'(dut_if.offsetX), 32'd0);
        check("rst.inside", 32'(dut_if.insideMap), 32'd0);
        check("rst.ack", 32'(dut_if.wrAck), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        count_busy(n);
        check("boot.busy_len", 32'(n), 32'd300);

        probe(0, 470, "floor");
        probe(130, 440, "gift");
        probe(130, 100, "bg");

        set_scroll(1250);
        probe(40, 470, "wrap");
        set_scroll(1300);
        probe(130, 440, "scroll_oob");

        do_write(2, 13, 0, "wr_gift");
        probe(130, 440, "after_wr");
        do_write(25, 0, 2, "wr_col_oob");
        probe(320, 32, "col_oob_map");
        do_write(3, 15, 2, "wr_row_oob");

        // A held request is acked every other cycle.
        dut_if.wrReq = 1'b1; dut_if.wrCol = 5'd4; dut_if.wrRow = 4'd2; dut_if.wrType = 2'd3;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat = {pat[2:0], dut_if.wrAck};
        end
        dut_if.wrReq = 1'b0;
        ref_map[2][4] = 2'd3;
        check("held_req.ack_pattern", 32'(pat), 32'b1010);
        @(negedge clk);
        probe(256, 64, "held_req.map");

        // Load beats a simultaneous write; the write lands once the load is done.
        dut_if.pixelX = 11'd0; dut_if.pixelY = 11'd470;
        @(negedge clk); @(negedge clk);
        dut_if.levelLoad = 1'b1;
        dut_if.wrReq = 1'b1; dut_if.wrCol = 5'd2; dut_if.wrRow = 4'd13; dut_if.wrType = 2'd3;
        n = 0; ack_early = 0; tile_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            dut_if.levelLoad = 1'b0;
            if (!dut_if.busy) break;
            n++;
            if (dut_if.wrAck) ack_early++;
            if (i > 0 && dut_if.Tile_type != 2'b00) tile_bad++;
        end
        check("reload.busy_len", 32'(n), 32'd300);
        check("reload.ack_during_load", 32'(ack_early), 32'd0);
        check("reload.tile_during_load", 32'(tile_bad), 32'd0);
        k = 0;
        while (!dut_if.wrAck && k < 20) begin
            @(negedge clk);
            k++;
        end
        dut_if.wrReq = 1'b0;
        check("reload.ack_after_busy", 32'(k), 32'd1);
        ref_load();
        ref_map[13][2] = 2'd3;
        @(negedge clk);
        probe(130, 440, "reload.pending_wr");
        probe(70, 470, "reload.floor");

        probe(700, 470, "px_oob");
        probe(100, 500, "py_oob");
        probe(64, 100, "grid_corner");

        set_scroll(777);
        probe(40, 470, "pre_reset");
        dut_if.levelLoad = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            dut_if.levelLoad = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("midload_rst.offX", 32'(dut_if.offsetX), 32'd0);
        check("midload_rst.tile", 32'(dut_if.Tile_type), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        scroll_ref = 0;
        ref_load();
        count_busy(n);
        check("midload_rst.busy_len", 32'(n), 32'd300);
        probe(40, 470, "post_reset_scroll");

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0: do_write($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 3), "rnd_wr");
                1: set_scroll($urandom_range(0, 2047));
                default: probe($urandom_range(0, 799), $urandom_range(0, 599), "rnd_probe");
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tile_map_addresser.md
Name: tile_map_addresser

Overview:
- Upstream stage of the tile bitmap renderer.
- Converts the VGA scan position into a tile coordinate in a horizontally scrolling world, looks up the tile type in an internal map, and emits the in-tile offsetX/offsetY and a 2-bit Tile_type that the bitmap stage consumes.
- Owns the map storage: loads a default level after reset or on request, and accepts single-tile updates from game logic (e.g. a collected gift becomes background).

Parameters:
- TILE_X_BITS, 6, log2 of tile width in pixels (64).
- TILE_Y_BITS, 5, log2 of tile height in pixels (32).
- MAP_COLS, 20, world width in tiles (1280 px).
- MAP_ROWS, 15, world height in tiles (480 px).
- SCREEN_W, 640, visible width in pixels.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at the start of each frame
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- scrollX  in  11  world X of screen column 0; sampled only on startOfFrame
- levelLoad  in  1  pulse: reload the default level
- wrReq  in  1  tile write request; held until wrAck
- wrCol  in  5  column to write
- wrRow  in  4  row to write
- wrType  in  2  new tile type
- wrAck  out  1  one-cycle acceptance strobe
- busy  out  1  high while a level load is in progress
- offsetX  out  11  pixel X inside the tile, 0..63
- offsetY  out  11  pixel Y inside the tile, 0..31
- Tile_type  out  2  00 background, 01 floor, 10 gift, 11 reserved
- insideMap  out  1  pixel lies inside the mapped area

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs are 0; busy is 1 on the first cycle after reset is released.
  - Map contents are undefined until LOAD completes.
  - The latched scroll value is 0.
- FSM states: LOAD, IDLE.
  - Reset → LOAD, with index = 0.
  - LOAD writes one entry per cycle, index 0..MAP_COLS*MAP_ROWS-1 (row-major: index = row*MAP_COLS + col).
  - Pattern: row MAP_ROWS-1 = 01. Row MAP_ROWS-2 = 10 when col%4 == 2. All other entries = 00.
  - After the last index (299) → IDLE on the next cycle. busy = (state == LOAD).
  - levelLoad in IDLE → LOAD with index = 0. levelLoad during LOAD is ignored; the load does not restart.
  - Reset asserted mid-load aborts the load and restarts LOAD from index 0.
- Writes:
  - Accepted only in IDLE. wrAck pulses 1 cycle, and the entry is updated on that same edge.
  - After an ack, the requester must drop wrReq or present new data. A still-high wrReq on the following cycle is treated as a new request, so a second ack occurs no earlier than 2 cycles after the first.
  - wrCol ≥ MAP_COLS or wrRow ≥ MAP_ROWS: acked, no write.
  - levelLoad and wrReq in the same IDLE cycle: the load wins. The write stays pending and is acked after the load completes.
- Scroll latch:
  - On startOfFrame, scrollLatched = scrollX if scrollX < MAP_COLS*64; otherwise 0.
- Read pipeline, latency 2 cycles from pixelX/pixelY to all outputs:
  - Stage 1 (registered):
    - worldX = pixelX + scrollLatched (12-bit). If ≥ 1280, subtract 1280 (wrap).
    - col = worldX >> 6; row = pixelY >> 5.
    - offX = worldX[5:0], zero-extended to 11 bits; offY = pixelY[4:0], zero-extended to 11 bits.
    - valid = (pixelX < SCREEN_W) and (pixelY < MAP_ROWS*32).
  - Stage 2 (registered):
    - Tile_type = map[row][col] if valid and not busy; else 00.
    - offsetX/offsetY pass through unchanged from stage 1.
    - insideMap = valid.
- A map write and a read of the same entry on the same edge: the read returns the old value.

Optional Feature:
- Macro: TILE_MAP_GRID_DEBUG_EN.
- Defined: at stage 2, if insideMap and (offX == 0 or offY == 0), Tile_type is forced to 01. This draws a floor-colored grid on tile borders for alignment debugging.
- Undefined: no forcing; behaviour exactly as above.

Test Plan:
- Reset, then release → busy = 1 for 300 cycles, then 0. Scan pixelY = 470 at pixelX = 0 → Tile_type = 01 two cycles later. pixelY = 440, pixelX = 130 (col 2) → 10. pixelY = 100 → 00.
- scrollX = 1250 latched on startOfFrame; pixelX = 40, pixelY = 470 → worldX = 10 (wrap), offsetX = 10, offsetY = 22, Tile_type = 01. scrollX = 1300 → latched 0.
- IDLE, wrReq with col = 2, row = 13, type = 00 → wrAck 1 cycle. Next frame, pixelX = 130, pixelY = 440 → Tile_type = 00. wrCol = 25 → ack with no map change.
- levelLoad and wrReq in the same cycle → busy 300 cycles, wrAck only after busy falls. Outputs report Tile_type = 00 throughout the load.
- pixelX = 700 or pixelY = 500 → insideMap = 0, Tile_type = 00. Reset pulsed at load index 150 → load restarts, busy 300 more cycles.
- With TILE_MAP_GRID_DEBUG_EN defined: pixelX = 64, pixelY = 100, scroll 0 → Tile_type = 01. Without it → 00.
